// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction sequencer for the calculator datapath.
// Buffers 8-bit instructions in a FIFO, then runs each one to completion:
// register-file read addressing, ALU handshake, write-back or UART send.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   inst_vld, inst_wd      instruction strobe and word {op, ra, rb, rc}
//   fifo_full, ovf         FIFO full flag, sticky dropped-instruction flag
//   rf_ra_addr, rf_rb_addr register-file read addresses
//   rf_we, rf_waddr        one-cycle write strobe and write address
//   rf_wsrc, rf_imm        write-data select (0 imm, 1 ALU) and immediate
//   alu_go, alu_op         ALU start pulse and op (0 add, 1 multiply)
//   alu_done               ALU result-valid pulse
//   tx_req, tx_ack         UART send request / acceptance
//   busy                   FSM active or FIFO non-empty
//   err                    sticky watchdog abort
//   inst_cnt               retired-instruction counter
//
// Optional feature macro: SEQ_CTRL_TIMEOUT_EN adds a watchdog on EXEC/SEND
// that aborts after TIMEOUT_CYCLES cycles and sets err.
module seq_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inst_vld,
    input  logic [7:0] inst_wd,
    output logic       fifo_full,
    output logic       ovf,
    output logic [1:0] rf_ra_addr,
    output logic [1:0] rf_rb_addr,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic       rf_wsrc,
    output logic [7:0] rf_imm,
    output logic       alu_go,
    output logic       alu_op,
    input  logic       alu_done,
    output logic       tx_req,
    input  logic       tx_ack,
    output logic       busy,
    output logic       err,
    output logic [7:0] inst_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       ir_q, ir_d;
    logic             fifo_full_q, fifo_full_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       rf_ra_addr_q, rf_ra_addr_d, rf_rb_addr_q, rf_rb_addr_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       rf_waddr_q, rf_waddr_d;
    logic             rf_wsrc_q, rf_wsrc_d;
    logic [7:0]       rf_imm_q, rf_imm_d;
    logic             alu_go_q, alu_go_d, alu_op_q, alu_op_d;
    logic             tx_req_q, tx_req_d;
    logic             busy_q, busy_d;
    logic [7:0]       inst_cnt_q, inst_cnt_d;

    logic full_c, pop_c, push_c, done_ok_c, tmo_hit_c, abort_c;

    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c     = (state_q == S_IDLE) && (count_q != '0);
    assign push_c    = inst_vld && (!full_c || pop_c);
    // alu_done is ignored during the alu_go cycle itself.
    assign done_ok_c = alu_done && !alu_go_q;
    assign abort_c   = tmo_hit_c &&
                       (((state_q == S_EXEC) && !done_ok_c) ||
                        ((state_q == S_SEND) && !tx_ack));

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts every cycle spent waiting in EXEC or SEND.
    always_comb begin
        tmo_d = '0;
        err_d = err_q;
        if ((state_q == S_EXEC) || (state_q == S_SEND)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (abort_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
    assign tmo_hit_c      = 1'b0;
    assign err            = 1'b0;
`endif

    // FIFO bookkeeping and sequencing FSM; outputs are registered from next state.
    always_comb begin
        state_d      = state_q;
        fifo_d       = fifo_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        ir_d         = ir_q;
        rf_ra_addr_d = rf_ra_addr_q;
        rf_rb_addr_d = rf_rb_addr_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wsrc_d    = rf_wsrc_q;
        rf_imm_d     = rf_imm_q;
        alu_op_d     = alu_op_q;
        rf_we_d      = 1'b0;
        alu_go_d     = 1'b0;
        tx_req_d     = 1'b0;
        inst_cnt_d   = inst_cnt_q;
        ovf_d        = ovf_q | (inst_vld & full_c & ~pop_c);

        if (push_c) begin
            fifo_d[wptr_q] = inst_wd;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    state_d      = S_DECODE;
                    ir_d         = fifo_q[rptr_q];
                    rf_ra_addr_d = ir_d[5:4];
                    rf_rb_addr_d = ir_d[3:2];
                    rf_imm_d     = {4'b0000, ir_d[3:0]};
                end
            end
            S_DECODE: begin
                case (ir_q[7:6])
                    OP_PUSH: begin
                        state_d    = S_WB;
                        rf_waddr_d = ir_q[5:4];
                        rf_wsrc_d  = 1'b0;
                        rf_we_d    = 1'b1;
                    end
                    OP_ADD, OP_MULT: begin
                        state_d  = S_EXEC;
                        alu_go_d = 1'b1;
                        alu_op_d = ir_q[7];
                    end
                    default: begin
                        state_d  = S_SEND;
                        tx_req_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (done_ok_c) begin
                    state_d    = S_WB;
                    rf_waddr_d = ir_q[1:0];
                    rf_wsrc_d  = 1'b1;
                    rf_we_d    = 1'b1;
                end else if (abort_c) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                state_d    = S_IDLE;
                inst_cnt_d = inst_cnt_q + 8'd1;
            end
            S_SEND: begin
                if (tx_ack) begin
                    state_d    = S_IDLE;
                    inst_cnt_d = inst_cnt_q + 8'd1;
                end else if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    tx_req_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        fifo_full_d = (count_d == CNT_W'(FIFO_DEPTH));
        busy_d      = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            ir_q         <= '0;
            fifo_full_q  <= 1'b0;
            ovf_q        <= 1'b0;
            rf_ra_addr_q <= '0;
            rf_rb_addr_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wsrc_q    <= 1'b0;
            rf_imm_q     <= '0;
            alu_go_q     <= 1'b0;
            alu_op_q     <= 1'b0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            inst_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fifo_q       <= fifo_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            ir_q         <= ir_d;
            fifo_full_q  <= fifo_full_d;
            ovf_q        <= ovf_d;
            rf_ra_addr_q <= rf_ra_addr_d;
            rf_rb_addr_q <= rf_rb_addr_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wsrc_q    <= rf_wsrc_d;
            rf_imm_q     <= rf_imm_d;
            alu_go_q     <= alu_go_d;
            alu_op_q     <= alu_op_d;
            tx_req_q     <= tx_req_d;
            busy_q       <= busy_d;
            inst_cnt_q   <= inst_cnt_d;
        end
    end

    assign fifo_full  = fifo_full_q;
    assign ovf        = ovf_q;
    assign rf_ra_addr = rf_ra_addr_q;
    assign rf_rb_addr = rf_rb_addr_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wsrc    = rf_wsrc_q;
    assign rf_imm     = rf_imm_q;
    assign alu_go     = alu_go_q;
    assign alu_op     = alu_op_q;
    assign tx_req     = tx_req_q;
    assign busy       = busy_q;
    assign inst_cnt   = inst_cnt_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed and randomized checks of seq_ctrl against an
// instruction-level model (queue of accepted instructions, retire count).
module tb_seq_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 32;

    logic       clk, rst_n, inst_vld, alu_done, tx_ack;
    logic [7:0] inst_wd;
    logic       fifo_full, ovf, rf_we, rf_wsrc, alu_go, alu_op, tx_req, busy, err;
    logic [1:0] rf_ra_addr, rf_rb_addr, rf_waddr;
    logic [7:0] rf_imm, inst_cnt;

    seq_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .inst_vld(inst_vld), .inst_wd(inst_wd),
        .fifo_full(fifo_full), .ovf(ovf), .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wsrc(rf_wsrc), .rf_imm(rf_imm), .alu_go(alu_go), .alu_op(alu_op),
        .alu_done(alu_done), .tx_req(tx_req), .tx_ack(tx_ack), .busy(busy),
        .err(err), .inst_cnt(inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    int         exp_cnt, alu_pend, tx_pend, alu_lat;
    bit         exp_ovf, alu_hold, tx_hold, alu_active, tx_wait, saw_go;
    int         n_tests, n_fail;
    logic [7:0] bw [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: retire pulses of the finished cycle, drive responders, observe new events.
    task automatic tick();
        logic [7:0] h;
        bit d, a;
        @(posedge clk);
        #1;
        inst_vld = 1'b0;
        d = alu_done;
        a = tx_ack;
        alu_done = 1'b0;
        tx_ack = 1'b0;
        if (a) begin
            chk("tx_req_drop", 32'(tx_req), 0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_cnt++;
            tx_wait = 1'b0;
        end else if (tx_wait) begin
            h = exp_q[0];
            chk("tx_req_hold", 32'(tx_req), 1);
            chk("tx_ra_hold", 32'(rf_ra_addr), 32'(h[5:4]));
        end
        if (d) chk("we_after_done", 32'(rf_we), 1);

        if (!alu_hold && alu_pend > 0) begin
            alu_pend--;
            if (alu_pend == 0) alu_done = 1'b1;
        end
        if (!tx_hold && tx_pend > 0) begin
            tx_pend--;
            if (tx_pend == 0) tx_ack = 1'b1;
        end

        if (alu_go) begin
            saw_go = 1'b1;
            if (exp_q.size() > 0) h = exp_q[0];
            if (exp_q.size() == 0 || alu_active || h[7:6] == 2'b00 || h[7:6] == 2'b11) begin
                chk("unexpected_go", 32'(alu_go), 0);
            end else begin
                chk("alu_op", 32'(alu_op), 32'(h[7]));
                chk("go_ra", 32'(rf_ra_addr), 32'(h[5:4]));
                chk("go_rb", 32'(rf_rb_addr), 32'(h[3:2]));
                alu_active = 1'b1;
                alu_pend = (alu_lat > 0) ? alu_lat : int'($urandom_range(1, 6));
            end
        end
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(rf_we), 0);
            end else begin
                h = exp_q[0];
                if (h[7:6] == 2'b00) begin
                    chk("push_waddr", 32'(rf_waddr), 32'(h[5:4]));
                    chk("push_wsrc", 32'(rf_wsrc), 0);
                    chk("push_imm", 32'(rf_imm), 32'({4'h0, h[3:0]}));
                end else if (h[7:6] == 2'b11) begin
                    chk("we_on_send", 32'(rf_we), 0);
                end else begin
                    chk("alu_waddr", 32'(rf_waddr), 32'(h[1:0]));
                    chk("alu_wsrc", 32'(rf_wsrc), 1);
                    chk("wb_timing", 32'(d), 1);
                    alu_active = 1'b0;
                end
                void'(exp_q.pop_front());
                exp_cnt++;
            end
        end
        if (tx_req && !tx_wait) begin
            if (exp_q.size() > 0) h = exp_q[0];
            if (exp_q.size() == 0 || h[7:6] != 2'b11) begin
                chk("unexpected_tx", 32'(tx_req), 0);
            end else begin
                chk("tx_ra", 32'(rf_ra_addr), 32'(h[5:4]));
                tx_wait = 1'b1;
                tx_pend = int'($urandom_range(1, 5));
            end
        end
    endtask

    task automatic put(input logic [7:0] w, input bit acc);
        inst_vld = 1'b1;
        inst_wd = w;
        if (acc) exp_q.push_back(w);
        else exp_ovf = 1'b1;
        tick();
    endtask

    task automatic run_idle(input int max_cyc);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < max_cyc) begin
            tick();
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic wait_go(input string tag);
        int k = 0;
        while (!saw_go && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(saw_go), 1);
    endtask

    // Lead SEND stalls the sequencer; following words fill the buffer, excess is dropped.
    task automatic burst(input logic [7:0] lead, input int n);
        int nb = 0;
        tx_hold = 1'b1;
        put(lead, 1'b1);
        for (int i = 0; i < n; i++) begin
            put(bw[i], nb < int'(DEPTH));
            if (nb < int'(DEPTH)) nb++;
        end
        chk("burst_full", 32'(fifo_full), 32'(nb == int'(DEPTH)));
        chk("burst_ovf", 32'(ovf), 32'(exp_ovf));
        tx_hold = 1'b0;
        run_idle(400);
        chk("burst_cnt", 32'(inst_cnt), 32'(exp_cnt[7:0]));
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_cnt = 0; exp_ovf = 1'b0;
        alu_pend = 0; tx_pend = 0; alu_lat = 0;
        alu_hold = 1'b0; tx_hold = 1'b0; alu_active = 1'b0; tx_wait = 1'b0;
        alu_done = 1'b0; tx_ack = 1'b0; inst_vld = 1'b0; inst_wd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_before;
        logic [7:0] w;
        n_tests = 0; n_fail = 0;
        clear_model();
        rst_n = 1'b0;
        #12;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_go", 32'(alu_go), 0);
        chk("rst_tx", 32'(tx_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(inst_cnt), 0);
        chk("rst_ovf_err_full", 32'({ovf, err, fifo_full}), 0);
        chk("rst_addr", 32'({rf_ra_addr, rf_rb_addr, rf_waddr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // PUSH r1 <- 3: rf_we in the cycle after E2.
        put(8'h13, 1'b1);
        chk("push_busy", 32'(busy), 1);
        tick();
        chk("push_e1_we", 32'(rf_we), 0);
        chk("push_e1_ra", 32'(rf_ra_addr), 1);
        tick();
        chk("push_e2_we", 32'(rf_we), 1);
        chk("push_e2_imm", 32'(rf_imm), 32'h03);
        tick();
        chk("push_e3_we", 32'(rf_we), 0);
        chk("push_cnt", 32'(inst_cnt), 1);

        // MULT r2 <- r0*r1, alu_done five cycles after alu_go.
        alu_lat = 5; saw_go = 1'b0;
        put(8'h86, 1'b1);
        wait_go("mult_go");
        repeat (5) tick();
        chk("mult_we_early", 32'(rf_we), 0);
        tick();
        chk("mult_we", 32'(rf_we), 1);
        chk("mult_waddr", 32'(rf_waddr), 2);
        run_idle(20);
        chk("mult_cnt", 32'(inst_cnt), 2);
        alu_lat = 0;

        // SEND r2 with tx_ack withheld for 20 cycles.
        tx_hold = 1'b1;
        put(8'hE0, 1'b1);
        repeat (22) tick();
        chk("send_stall_req", 32'(tx_req), 1);
        tx_hold = 1'b0;
        run_idle(20);
        chk("send_cnt", 32'(inst_cnt), 3);

        // Five instructions behind a stalled SEND: four kept, one dropped.
        bw[0] = 8'h15; bw[1] = 8'h56; bw[2] = 8'h9B; bw[3] = 8'hD0; bw[4] = 8'h0F;
        burst(8'hC0, 5);
        chk("ovf_cnt", 32'(inst_cnt), 8);

        // Reset while alu_go is high discards the in-flight and buffered work.
        alu_hold = 1'b1; saw_go = 1'b0;
        put(8'h46, 1'b1);
        put(8'h11, 1'b1);
        wait_go("rst_exec_go");
        chk("rst_exec_go_hi", 32'(alu_go), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_go", 32'(alu_go), 0);
        chk("rst_async_we_tx", 32'({rf_we, tx_req}), 0);
        chk("rst_async_busy", 32'(busy), 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_post_busy", 32'(busy), 0);
        chk("rst_post_cnt", 32'(inst_cnt), 0);
        chk("rst_post_ovf", 32'(ovf), 0);

        // Random single instructions with random ALU/UART latencies.
        for (int i = 0; i < 24; i++) begin
            w = 8'($urandom);
            put(w, 1'b1);
            run_idle(40);
            chk("rand_cnt", 32'(inst_cnt), 32'(exp_cnt[7:0]));
        end

        // Random bursts behind a stalled SEND.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 8; i++) bw[i] = 8'($urandom);
            w = 8'($urandom);
            burst({2'b11, w[5:0]}, int'($urandom_range(1, 7)));
        end

        // ADD with alu_done never returned.
        alu_hold = 1'b1; saw_go = 1'b0;
        put(8'h46, 1'b1);
        wait_go("tmo_go");
        cnt_before = exp_cnt;
        repeat (TMO - 1) tick();
        chk("tmo_pre_busy", 32'(busy), 1);
        tick();
`ifdef SEQ_CTRL_TIMEOUT_EN
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_cnt", 32'(inst_cnt), 32'(cnt_before[7:0]));
        void'(exp_q.pop_front());
        alu_active = 1'b0; alu_pend = 0; alu_hold = 1'b0;
        repeat (3) tick();
        chk("tmo_no_we", 32'(rf_we), 0);
`else
        chk("notmo_busy", 32'(busy), 1);
        chk("notmo_err", 32'(err), 0);
        alu_hold = 1'b0;
        run_idle(20);
        chk("notmo_cnt", 32'(inst_cnt), 32'(cnt_before[7:0]) + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
